point_add_driver: RTL and testbench
===================================

# point_add_driver

Job sequencer on the initiator side of the `point_add` engine's Reset/Done protocol. It accepts point pairs over a valid/ready stream and resolves degenerate cases without the engine. For all other pairs it arms the engine, waits for `Done`, and captures the result. It returns `R` with a status code over a second valid/ready stream. It sits between MSM bucket control and a single `point_add` instance and owns the engine's reset line.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum RUN cycles before abort. Range 2..65535.
- `ARM_CYCLES`, default 2: cycles `add_Reset` is held high before each engine run. Minimum 1.
- `clk`  in  1  single clock, rising edge.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  job offered.
- `in_ready`  out  1  driver can accept a job.
- `in_P`, `in_Q`  in  `curve_point_t`  operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_R`  out  `curve_point_t`  result.
- `out_status`  out  2  status code:
  - 00: engine result.
  - 01: shortcut result.
  - 10: timeout.
  - 11: unsupported doubling.
- `jobs_done`  out  16  count of completed output handshakes; wraps at 65535→0.
- `add_Reset`  out  1  active-high reset to the engine.
- `add_P`, `add_Q`  out  `curve_point_t`  registered operands to the engine.
- `add_Done`  in  1  engine done.
- `add_R`  in  `curve_point_t`  engine result.

## Operation
States are IDLE, ARM, RUN and RESP.
- **IDLE**
  - `in_ready`=1, `add_Reset`=1.
  - On `in_valid && in_ready`, latch `in_P`/`in_Q` into `add_P`/`add_Q`, then classify in priority order:
    1. Q==inf_point: R=P, status 01, go to RESP.
    2. P==inf_point: R=Q, status 01, go to RESP.
    3. P==Q: R=inf_point, status 11, go to RESP.
    4. P.x==Q.x: R=inf_point, status 01, go to RESP.
    5. Otherwise: clear the arm counter, go to ARM.
- **ARM**
  - `add_Reset`=1 for exactly `ARM_CYCLES` cycles.
  - Clear the timeout counter, then go to RUN.
- **RUN**
  - `add_Reset`=0; the timeout counter increments each cycle.
  - `add_Done` is sampled only in RUN; the engine's `Done` is combinational and may glitch while in ARM.
  - `add_Done`=1: capture `add_R`, status 00, go to RESP. This takes priority over timeout in the same cycle.
  - Counter reaches `TIMEOUT_CYCLES`: R=inf_point, status 10, go to RESP.
- **RESP**
  - `out_valid`=1, `add_Reset`=1.
  - `out_R`/`out_status` stay stable until `out_ready`.
  - On handshake, increment `jobs_done` and go to IDLE.
- `in_ready` is 0 outside IDLE; there is no input buffering.
- `add_P`/`add_Q` hold their values from ARM through RESP.

## Timing
- **Reset values** (Reset_n=0 at a clock edge):
  - State IDLE.
  - `in_ready`=0 while `Reset_n`=0.
  - `out_valid`=0, `add_Reset`=1.
  - `out_R`=inf_point, `out_status`=00.
  - `add_P`=`add_Q`=inf_point.
  - `jobs_done`=0, all counters 0.
- `in_ready`=1 in the first cycle after `Reset_n` returns high.
- **Shortcut latency:** `out_valid` is high in the cycle after acceptance.
- **Engine latency:** 1 + `ARM_CYCLES` + N cycles from the accept edge to `out_valid`, where N is the number of RUN cycles up to and including the one in which `add_Done` is sampled.
- **Back-to-back:** after an output handshake, `in_ready` is 1 in the next cycle, so the minimum job spacing is 2 cycles (shortcut jobs).
- **Reset mid-job:** the job is dropped with no output. `add_Reset` is 1 from the following cycle. `jobs_done` is cleared.
- `out_ready` asserted while `out_valid`=0 is ignored.

## Configuration
- Macro: `POINT_ADD_DRIVER_TIMEOUT_EN`.
- **Defined:** the timeout counter and the RUN→RESP abort path exist.
- **Undefined:** no counter; RUN waits for `add_Done` indefinitely and status 10 is never produced. `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Reset:** hold `Reset_n`=0 for 3 cycles.
  - During reset: `in_ready`=0, `out_valid`=0, `add_Reset`=1, `jobs_done`=0.
  - After release: `in_ready`=1 on the next cycle.
- **Shortcut:** P=(5,7), Q=inf_point.
  - `out_valid` goes high 1 cycle after accept with `out_R`=(5,7), status 01.
  - `add_Reset` never goes low.
- **Normal job** (engine stub raises `add_Done` on the 10th RUN cycle with R=(0x11,0x22)):
  - `add_Reset` is high for exactly 2 cycles, then low.
  - `out_R`=(0x11,0x22), status 00, `out_valid` 13 cycles after accept.
  - The stub also glitches `add_Done` during ARM; this must be ignored.
- **Backpressure:** hold `out_ready`=0 for 5 cycles.
  - `out_R`/`out_status` stay stable and `in_ready`=0 throughout.
  - On handshake, `jobs_done` increments and `in_ready`=1 the next cycle.
- **Timeout:** `TIMEOUT_CYCLES`=16, engine never asserts `add_Done`.
  - With the macro defined: status 10, `out_R`=inf_point after 16 RUN cycles.
  - With the macro undefined: still in RUN after 1000 cycles.
- **Degenerate pairs and reset mid-job:**
  - P==Q=(3,4) → status 11, `out_R`=inf_point.
  - P=(3,4), Q=(3,9) → status 01, `out_R`=inf_point.
  - `Reset_n`=0 mid-RUN → no output, IDLE after release.

Source files
------------

// File: rtl/point_add_driver_if.sv
// Curve point type plus the job-stream and engine-side bundle of point_add_driver.
// Point at infinity is encoded as (0,0), which is never a valid affine curve point.
package point_add_pkg;
    localparam int COORD_W = 32;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } curve_point_t;

    localparam curve_point_t INF_POINT = '0;
endpackage

interface point_add_driver_if;
    import point_add_pkg::*;

    logic         in_valid;
    logic         in_ready;
    curve_point_t in_P;
    curve_point_t in_Q;
    logic         out_valid;
    logic         out_ready;
    curve_point_t out_R;
    logic [1:0]   out_status;
    logic [15:0]  jobs_done;
    logic         add_Reset;
    curve_point_t add_P;
    curve_point_t add_Q;
    logic         add_Done;
    curve_point_t add_R;

    // master: the driver itself; slave: bucket control plus the engine
    modport master (
        input  in_valid, in_P, in_Q, out_ready, add_Done, add_R,
        output in_ready, out_valid, out_R, out_status, jobs_done,
               add_Reset, add_P, add_Q
    );

    modport slave (
        output in_valid, in_P, in_Q, out_ready, add_Done, add_R,
        input  in_ready, out_valid, out_R, out_status, jobs_done,
               add_Reset, add_P, add_Q
    );
endinterface

// File: rtl/point_add_driver.sv
// Job sequencer for one point_add engine: shortcuts degenerate pairs, otherwise arms/runs the engine.
// Optional RUN timeout abort enabled by POINT_ADD_DRIVER_TIMEOUT_EN.
module point_add_driver
    import point_add_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned ARM_CYCLES     = 2
) (
    input  logic               clk,
    input  logic               Reset_n,
    point_add_driver_if.master bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, RESP} state_t;

    localparam logic [1:0]  ST_ENGINE   = 2'b00;
    localparam logic [1:0]  ST_SHORTCUT = 2'b01;
    localparam logic [1:0]  ST_UNSUPP   = 2'b11;
    localparam logic [15:0] ARM_LAST    = 16'(ARM_CYCLES - 1);

    state_t       state_q, state_d;
    logic [15:0]  arm_cnt_q, arm_cnt_d;
    curve_point_t add_P_q, add_P_d;
    curve_point_t add_Q_q, add_Q_d;
    curve_point_t out_R_q, out_R_d;
    logic [1:0]   out_status_q, out_status_d;
    logic [15:0]  jobs_done_q, jobs_done_d;
    logic         in_ready;

`ifdef POINT_ADD_DRIVER_TIMEOUT_EN
    localparam logic [1:0]  ST_TIMEOUT = 2'b10;
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
`endif

    assign in_ready = (state_q == IDLE) && Reset_n;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            arm_cnt_q    <= '0;
            add_P_q      <= INF_POINT;
            add_Q_q      <= INF_POINT;
            out_R_q      <= INF_POINT;
            out_status_q <= ST_ENGINE;
            jobs_done_q  <= '0;
`ifdef POINT_ADD_DRIVER_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            add_P_q      <= add_P_d;
            add_Q_q      <= add_Q_d;
            out_R_q      <= out_R_d;
            out_status_q <= out_status_d;
            jobs_done_q  <= jobs_done_d;
`ifdef POINT_ADD_DRIVER_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        add_P_d      = add_P_q;
        add_Q_d      = add_Q_q;
        out_R_d      = out_R_q;
        out_status_d = out_status_q;
        jobs_done_d  = jobs_done_q;
`ifdef POINT_ADD_DRIVER_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    add_P_d = bus.in_P;
                    add_Q_d = bus.in_Q;
                    state_d = RESP;
                    // Priority order matters: infinity checks must precede the equality checks.
                    if (bus.in_Q == INF_POINT) begin
                        out_R_d      = bus.in_P;
                        out_status_d = ST_SHORTCUT;
                    end else if (bus.in_P == INF_POINT) begin
                        out_R_d      = bus.in_Q;
                        out_status_d = ST_SHORTCUT;
                    end else if (bus.in_P == bus.in_Q) begin
                        out_R_d      = INF_POINT;
                        out_status_d = ST_UNSUPP;
                    end else if (bus.in_P.x == bus.in_Q.x) begin
                        out_R_d      = INF_POINT;
                        out_status_d = ST_SHORTCUT;
                    end else begin
                        arm_cnt_d = '0;
                        state_d   = ARM;
                    end
                end
            end

            ARM: begin
                // Engine Done is not trustworthy here; it is only looked at in RUN.
                if (arm_cnt_q == ARM_LAST) begin
                    state_d = RUN;
`ifdef POINT_ADD_DRIVER_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    arm_cnt_d = arm_cnt_q + 16'd1;
                end
            end

            RUN: begin
`ifdef POINT_ADD_DRIVER_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                if (bus.add_Done) begin
                    out_R_d      = bus.add_R;
                    out_status_d = ST_ENGINE;
                    state_d      = RESP;
`ifdef POINT_ADD_DRIVER_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    out_R_d      = INF_POINT;
                    out_status_d = ST_TIMEOUT;
                    state_d      = RESP;
`endif
                end
            end

            RESP: begin
                if (bus.out_ready) begin
                    jobs_done_d = jobs_done_q + 16'd1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == RESP);
    assign bus.out_R      = out_R_q;
    assign bus.out_status = out_status_q;
    assign bus.jobs_done  = jobs_done_q;
    assign bus.add_Reset  = (state_q != RUN);
    assign bus.add_P      = add_P_q;
    assign bus.add_Q      = add_Q_q;
endmodule

// File: tb/tb_point_add_driver.sv
// Directed bench for point_add_driver with an engine stub and an expected-result queue.
module tb_point_add_driver;
    import point_add_pkg::*;

    localparam int ARM     = 2;
    localparam int TMO     = 16;
    localparam int DONE_AT = 10;

    typedef struct packed {
        curve_point_t r;
        logic [1:0]   st;
    } exp_t;

    logic clk = 1'b0;
    logic Reset_n;

    point_add_driver_if bus ();

    point_add_driver #(
        .TIMEOUT_CYCLES(TMO),
        .ARM_CYCLES    (ARM)
    ) dut (
        .clk    (clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    curve_point_t pt_57, pt_89, pt_a, pt_b, pt_c, pt_34, pt_39, pt_r, pt_junk;

    // Engine stub: Done on the DONE_AT-th RUN cycle, and a spurious Done while held in reset.
    logic eng_en;
    int   run_cnt;
    logic stub_done;

    always @(posedge clk) begin
        if (bus.add_Reset) run_cnt <= 0;
        else               run_cnt <= run_cnt + 1;
    end

    assign stub_done    = eng_en && !bus.add_Reset && (run_cnt == DONE_AT - 1);
    assign bus.add_Done = eng_en && (bus.add_Reset || stub_done);
    assign bus.add_R    = stub_done ? pt_r : pt_junk;

    int low_cycles = 0;
    always @(negedge clk) if (!bus.add_Reset) low_cycles <= low_cycles + 1;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_jobs = '0;
    exp_t        sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input curve_point_t p, input curve_point_t q, input bit push,
                        input curve_point_t er, input logic [1:0] est);
        bus.in_P     = p;
        bus.in_Q     = q;
        bus.in_valid = 1'b1;
        if (push) sb.push_back('{r: er, st: est});
        chk("in_ready_at_offer", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, input int budget, output int lat);
        lat = start;
        while (!bus.out_valid && lat < budget) begin
            tick();
            lat++;
        end
        chk("out_valid_within_budget", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic take();
        exp_t e;
        e = '0;
        chk("scoreboard_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) e = sb.pop_front();
        chk("out_R", 64'(bus.out_R), 64'(e.r));
        chk("out_status", 64'(bus.out_status), 64'(e.st));
        bus.out_ready = 1'b1;
        exp_jobs++;
        tick();
        bus.out_ready = 1'b0;
        chk("jobs_done", 64'(bus.jobs_done), 64'(exp_jobs));
        chk("in_ready_after_handshake", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int lc;

        pt_57   = '{x: 32'd5,    y: 32'd7};
        pt_89   = '{x: 32'd8,    y: 32'd9};
        pt_a    = '{x: 32'd100,  y: 32'd200};
        pt_b    = '{x: 32'd300,  y: 32'd400};
        pt_c    = '{x: 32'd500,  y: 32'd600};
        pt_34   = '{x: 32'd3,    y: 32'd4};
        pt_39   = '{x: 32'd3,    y: 32'd9};
        pt_r    = '{x: 32'h11,   y: 32'h22};
        pt_junk = '{x: 32'hdead, y: 32'hbeef};

        Reset_n       = 1'b0;
        eng_en        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_P      = INF_POINT;
        bus.in_Q      = INF_POINT;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_add_Reset", 64'(bus.add_Reset), 64'd1);
            chk("rst_jobs_done", 64'(bus.jobs_done), 64'd0);
        end
        chk("rst_out_R", 64'(bus.out_R), 64'(INF_POINT));
        chk("rst_out_status", 64'(bus.out_status), 64'd0);
        chk("rst_add_P", 64'(bus.add_P), 64'(INF_POINT));
        chk("rst_add_Q", 64'(bus.add_Q), 64'(INF_POINT));
        Reset_n = 1'b1;
        tick();
        chk("in_ready_after_release", 64'(bus.in_ready), 64'd1);

        // Shortcut Q=inf, engine reset never released
        lc = low_cycles;
        send(pt_57, INF_POINT, 1'b1, pt_57, 2'b01);
        wait_out(1, 5, lat);
        chk("shortcut_latency", 64'(lat), 64'd1);
        take();
        chk("shortcut_add_Reset_never_low", 64'(low_cycles), 64'(lc));

        // Back-to-back shortcut P=inf
        send(INF_POINT, pt_89, 1'b1, pt_89, 2'b01);
        wait_out(1, 5, lat);
        chk("p_inf_latency", 64'(lat), 64'd1);
        take();

        // Normal engine job, Done glitches during ARM, then output backpressure
        eng_en = 1'b1;
        send(pt_a, pt_b, 1'b1, pt_r, 2'b00);
        chk("arm_cycle1_add_Reset", 64'(bus.add_Reset), 64'd1);
        tick();
        chk("arm_cycle2_add_Reset", 64'(bus.add_Reset), 64'd1);
        tick();
        chk("run_cycle1_add_Reset", 64'(bus.add_Reset), 64'd0);
        chk("run_add_P_held", 64'(bus.add_P), 64'(pt_a));
        chk("run_add_Q_held", 64'(bus.add_Q), 64'(pt_b));
        wait_out(3, 40, lat);
        chk("engine_latency", 64'(lat), 64'(1 + ARM + DONE_AT));
        eng_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_R_stable", 64'(bus.out_R), 64'(pt_r));
            chk("bp_out_status_stable", 64'(bus.out_status), 64'd0);
            tick();
        end
        take();

`ifdef POINT_ADD_DRIVER_TIMEOUT_EN
        // Engine never finishes: abort after TMO RUN cycles
        send(pt_a, pt_c, 1'b1, INF_POINT, 2'b10);
        wait_out(1, 60, lat);
        chk("timeout_latency", 64'(lat), 64'(1 + ARM + TMO));
        take();
        send(pt_b, pt_c, 1'b0, INF_POINT, 2'b00);
        for (int i = 0; i < ARM + 4; i++) tick();
`else
        // Without the abort path, RUN waits forever
        send(pt_a, pt_c, 1'b0, INF_POINT, 2'b00);
        for (int i = 0; i < 1000; i++) tick();
        chk("no_timeout_out_valid", 64'(bus.out_valid), 64'd0);
`endif
        chk("midrun_add_Reset_low", 64'(bus.add_Reset), 64'd0);

        // Reset mid-RUN drops the job
        Reset_n = 1'b0;
        tick();
        chk("midrun_rst_add_Reset", 64'(bus.add_Reset), 64'd1);
        chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun_rst_jobs_done", 64'(bus.jobs_done), 64'd0);
        exp_jobs = '0;
        Reset_n  = 1'b1;
        tick();
        chk("midrun_release_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrun_no_output", 64'(bus.out_valid), 64'd0);
        end
        chk("midrun_scoreboard_empty", 64'(sb.size()), 64'd0);

        // Degenerate pairs
        send(pt_34, pt_34, 1'b1, INF_POINT, 2'b11);
        wait_out(1, 5, lat);
        chk("doubling_latency", 64'(lat), 64'd1);
        take();
        send(pt_34, pt_39, 1'b1, INF_POINT, 2'b01);
        wait_out(1, 5, lat);
        chk("neg_pair_latency", 64'(lat), 64'd1);
        take();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
